// File: rtl/phy_pkg.sv
// Constants and state encoding shared by the transmit serializer and the receive PHY.
package phy_pkg;

    localparam int                  SYMBOL_W        = 8;
    localparam logic [SYMBOL_W-1:0] COM_SYMBOL      = 8'hBC;
    localparam int                  SYNC_COUNT_DFLT = 4;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } phy_state_e;

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Byte-in / serial-out signal bundle of the transmit serializer.
// Handshake: a byte moves on a rising edge where valid_in && ready_out; the producer
// keeps data_in stable while valid_in is high until that edge, and ready_out is combinational.
interface paralelo_serial_tx_if;
    import phy_pkg::*;

    logic [SYMBOL_W-1:0] data_in;
    logic                valid_in;
    logic                ready_out;
    logic                data_out;
    logic                byte_strobe_out;
    logic                data_flag_out;
    logic                active_out;
    phy_state_e          state_dbg;

    modport slave (
        input  data_in, valid_in,
        output ready_out, data_out, byte_strobe_out, data_flag_out, active_out, state_dbg
    );

    modport master (
        output data_in, valid_in,
        input  ready_out, data_out, byte_strobe_out, data_flag_out, active_out, state_dbg
    );

endinterface

// File: rtl/tx_shifter8.sv
// Free-running 8-bit symbol shifter: loads a new symbol every 8 edges and emits it MSB first.
module tx_shifter8 (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic [7:0] sym_i,
    output logic       data_o,
    output logic       byte_strobe_o,
    output logic       boundary_o
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       data_q, data_d;
    logic       strobe_q, strobe_d;

    assign boundary_o    = (bit_cnt_q == 3'd0);
    assign data_o        = data_q;
    assign byte_strobe_o = strobe_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = {shift_q[5:0], 1'b0};
        data_d    = shift_q[6];
        strobe_d  = 1'b0;
        if (boundary_o) begin
            shift_d  = sym_i[6:0];
            data_d   = sym_i[7];
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            data_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
        end
    end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Transmit serializer top: COM preamble FSM, one-entry holding register and handshake
// in front of the symbol shifter.
module paralelo_serial_tx #(
    parameter logic [7:0] COM_SYMBOL = phy_pkg::COM_SYMBOL,
    parameter int         SYNC_COUNT = phy_pkg::SYNC_COUNT_DFLT
) (
    input  logic                 clk_32f,
    input  logic                 rst,
    paralelo_serial_tx_if.slave  bus
);
    import phy_pkg::*;

    localparam int                SYNC_W    = $clog2(SYNC_COUNT + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COUNT);

    phy_state_e        state_q, state_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              hold_valid_q, hold_valid_d;
    logic              flag_q, flag_d;

    logic       boundary;
    logic       ready;
    logic       transfer;
    logic       consume;
    logic [7:0] sym;

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        flag_d       = flag_q;
        sym          = COM_SYMBOL;
        ready        = 1'b0;
        consume      = 1'b0;

        case (state_q)
            SYNC: begin
                if (boundary) begin
                    sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                    if (sync_cnt_d == SYNC_LAST) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // A full hold can still take a byte on the edge that empties it into the shifter.
                ready = !hold_valid_q || boundary;
                if (boundary && hold_valid_q) begin
                    sym     = hold_data_q;
                    consume = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

        if (boundary) flag_d = consume;

        transfer = bus.valid_in && ready;
        if (consume) hold_valid_d = 1'b0;
        if (transfer) begin
            hold_data_d  = bus.data_in;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            sync_cnt_q   <= '0;
            hold_data_q  <= 8'd0;
            hold_valid_q <= 1'b0;
            flag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            flag_q       <= flag_d;
        end
    end

    tx_shifter8 u_shifter (
        .clk_32f       (clk_32f),
        .rst           (rst),
        .sym_i         (sym),
        .data_o        (bus.data_out),
        .byte_strobe_o (bus.byte_strobe_out),
        .boundary_o    (boundary)
    );

    assign bus.ready_out     = ready;
    assign bus.data_flag_out = flag_q;
    assign bus.active_out    = (state_q == ACTIVE);
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: preamble, single byte, back-to-back bytes,
// COM-valued data, mid-symbol reset, and a one-COM preamble instance.
module tb_paralelo_serial_tx;
    import phy_pkg::*;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] com = 8'hBC;

    always #5 clk = ~clk;

    paralelo_serial_tx_if bus0 ();
    paralelo_serial_tx_if bus1 ();

    paralelo_serial_tx u_dut0 (
        .clk_32f (clk),
        .rst     (rst0),
        .bus     (bus0)
    );

    paralelo_serial_tx #(.SYNC_COUNT(1)) u_dut1 (
        .clk_32f (clk),
        .rst     (rst1),
        .bus     (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance over bit positions from_bit..to_bit of sym on dut0, checking line, strobe and flag.
    task automatic run_sym(input logic [7:0] sym, input logic flag,
                           input int from_bit, input int to_bit, input string tag);
        for (int i = from_bit; i <= to_bit; i++) begin
            step();
            chk($sformatf("%s_data_b%0d", tag, i), bus0.data_out, sym[7-i]);
            chk($sformatf("%s_strobe_b%0d", tag, i), bus0.byte_strobe_out, (i == 0));
            chk($sformatf("%s_flag_b%0d", tag, i), bus0.data_flag_out, flag);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},   bus0.data_out, 1'b0);
        chk({tag, "_strobe"}, bus0.byte_strobe_out, 1'b0);
        chk({tag, "_flag"},   bus0.data_flag_out, 1'b0);
        chk({tag, "_active"}, bus0.active_out, 1'b0);
        chk({tag, "_ready"},  bus0.ready_out, 1'b0);
    endtask

    task automatic preamble(input string tag);
        for (int s = 0; s < 3; s++) begin
            run_sym(com, 1'b0, 0, 7, tag);
            chk({tag, "_active_low"}, bus0.active_out, 1'b0);
            chk({tag, "_ready_low"},  bus0.ready_out, 1'b0);
        end
        run_sym(com, 1'b0, 0, 0, {tag, "4"});
        chk({tag, "_active_high"}, bus0.active_out, 1'b1);
        chk({tag, "_state"},       bus0.state_dbg, ACTIVE);
        chk({tag, "_ready_high"},  bus0.ready_out, 1'b1);
    endtask

    initial begin
        logic [7:0] b1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.valid_in = 1'b0;
        bus0.data_in  = 8'h00;
        bus1.valid_in = 1'b0;
        bus1.data_in  = 8'h00;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_state", bus0.state_dbg, SYNC);
        rst0 = 1'b0;

        // Preamble: edges 0..24
        preamble("pre");

        // Single byte 0xA5 accepted at edge 26, sent at edge 32
        run_sym(com, 1'b0, 1, 1, "idle25");
        bus0.valid_in = 1'b1;
        bus0.data_in  = 8'hA5;
        chk("a5_ready_before", bus0.ready_out, 1'b1);
        run_sym(com, 1'b0, 2, 2, "idle26");
        bus0.valid_in = 1'b0;
        chk("a5_ready_full", bus0.ready_out, 1'b0);
        run_sym(com, 1'b0, 3, 7, "idle27");
        chk("a5_ready_boundary", bus0.ready_out, 1'b1);
        run_sym(8'hA5, 1'b1, 0, 7, "a5");
        run_sym(com, 1'b0, 0, 0, "after_a5");

        // Back-to-back 0x01, 0x02, 0x03
        bus0.valid_in = 1'b1;
        bus0.data_in  = 8'h01;
        chk("b2b_ready_empty", bus0.ready_out, 1'b1);
        run_sym(com, 1'b0, 1, 1, "b2b_acc1");
        bus0.data_in = 8'h02;
        chk("b2b_ready_full", bus0.ready_out, 1'b0);
        run_sym(com, 1'b0, 2, 7, "b2b_idle");
        chk("b2b_ready_b1", bus0.ready_out, 1'b1);
        run_sym(8'h01, 1'b1, 0, 0, "b01");
        bus0.data_in = 8'h03;
        chk("b2b_ready_mid", bus0.ready_out, 1'b0);
        run_sym(8'h01, 1'b1, 1, 7, "b01");
        chk("b2b_ready_b2", bus0.ready_out, 1'b1);
        run_sym(8'h02, 1'b1, 0, 0, "b02");
        bus0.valid_in = 1'b0;
        run_sym(8'h02, 1'b1, 1, 7, "b02");
        run_sym(8'h03, 1'b1, 0, 7, "b03");
        run_sym(com, 1'b0, 0, 7, "after_b2b");

        // COM-valued data at a boundary with empty hold: COM first, then data-flagged 0xBC
        bus0.valid_in = 1'b1;
        bus0.data_in  = 8'hBC;
        chk("bc_ready", bus0.ready_out, 1'b1);
        run_sym(com, 1'b0, 0, 0, "bc_nobypass");
        bus0.valid_in = 1'b0;
        chk("bc_ready_full", bus0.ready_out, 1'b0);
        run_sym(com, 1'b0, 1, 7, "bc_wait");
        run_sym(8'hBC, 1'b1, 0, 7, "bc_data");

        // Fill hold with 0x77, then reset at bit_cnt=3
        bus0.valid_in = 1'b1;
        bus0.data_in  = 8'h77;
        run_sym(com, 1'b0, 0, 0, "r_fill");
        bus0.valid_in = 1'b0;
        run_sym(com, 1'b0, 1, 2, "r_mid");
        chk("r_mid_data_before", bus0.data_out, 1'b1);
        rst0 = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        step();
        chk_reset_outputs("rst_held");
        rst0 = 1'b0;
        preamble("pre2");
        run_sym(com, 1'b0, 1, 7, "post_rst_idle");
        run_sym(com, 1'b0, 0, 7, "post_rst_nohold");

        // SYNC_COUNT=1 instance
        chk("s1_reset_active", bus1.active_out, 1'b0);
        rst1 = 1'b0;
        step();
        chk("s1_e0_data",   bus1.data_out, 1'b1);
        chk("s1_e0_strobe", bus1.byte_strobe_out, 1'b1);
        chk("s1_e0_active", bus1.active_out, 1'b1);
        chk("s1_e0_ready",  bus1.ready_out, 1'b1);
        bus1.valid_in = 1'b1;
        bus1.data_in  = 8'h3C;
        step();
        bus1.valid_in = 1'b0;
        chk("s1_ready_full", bus1.ready_out, 1'b0);
        repeat (6) step();
        b1 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("s1_data_b%0d", i),   bus1.data_out, b1[7-i]);
            chk($sformatf("s1_flag_b%0d", i),   bus1.data_flag_out, 1'b1);
            chk($sformatf("s1_strobe_b%0d", i), bus1.byte_strobe_out, (i == 0));
        end
        step();
        chk("s1_after_flag", bus1.data_flag_out, 1'b0);
        chk("s1_after_data", bus1.data_out, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
Transmit-side byte serializer that drives the single serial line later deserialized by the receive PHY. It accepts bytes through a valid/ready handshake into a one-entry holding register and shifts them out MSB-first at one bit per clk_32f cycle. Before any data is accepted, it emits a COM preamble so the receiver can align and go active. Whenever no data is pending at a symbol boundary, it sends the COM idle symbol.

Parameters:
COM_SYMBOL, 8'hBC, idle/alignment symbol sent when no data is pending and during the preamble
SYNC_COUNT, 4, number of COM symbols loaded after reset before data is accepted (minimum 1)

Ports:
clk_32f  input  1  serial bit clock; the only clock; all state is on its rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  8  byte to transmit
valid_in  input  1  data_in is valid
ready_out  output  1  block accepts data_in on this edge; transfer = valid_in && ready_out
data_out  output  1  registered serial bit, MSB first
byte_strobe_out  output  1  registered; high in the cycle data_out carries bit 7 of any symbol
data_flag_out  output  1  registered; high for all 8 cycles of a data symbol, low for COM
active_out  output  1  registered; preamble complete, data path open

Behaviour:
- State: bit_cnt[2:0], shift[6:0], hold_data[7:0], hold_valid, sync_cnt (width sized for SYNC_COUNT), FSM {SYNC, ACTIVE}.
- Reset (async, any time, including mid-symbol): data_out=0, byte_strobe_out=0, data_flag_out=0, active_out=0, bit_cnt=0, shift=0, hold_valid=0, sync_cnt=0, FSM=SYNC. Held data is discarded.
- Boundary edge: any edge where bit_cnt==0. bit_cnt increments mod 8 on every edge.
- Symbol selection at a boundary edge:
  - If FSM=ACTIVE and hold_valid=1: symbol S=hold_data and data_flag_out<=1.
  - Otherwise: S=COM_SYMBOL and data_flag_out<=0.
- Load at a boundary edge: data_out<=S[7], shift<=S[6:0], byte_strobe_out<=1.
- Non-boundary edge: data_out<=shift[6], shift<=shift<<1, byte_strobe_out<=0. data_flag_out holds its value.
- SYNC state:
  - Each COM load increments sync_cnt.
  - The edge loading the SYNC_COUNT-th COM sets FSM=ACTIVE and active_out<=1.
  - ready_out=0 throughout SYNC.
- ACTIVE state: ready_out (combinational) = !hold_valid || bit_cnt==0.
- Holding register:
  - A transfer writes hold_data<=data_in and sets hold_valid.
  - A boundary edge that consumes hold clears hold_valid, unless a simultaneous transfer refills it (the new byte wins, the old byte is the one sent).
  - No bypass: a transfer on a boundary edge with hold empty sends COM now and the data at the next boundary.
- Latency: from transfer edge to MSB on data_out is 1–8 cycles, aligned to the next boundary. Maximum throughput is one byte per 8 cycles.
- data_in equal to COM_SYMBOL is sent as data (data_flag_out=1); avoiding ambiguity on the line is the responsibility of the upstream logic.
- valid_in while ready_out=0 is ignored; the producer must hold the byte until a transfer occurs.
- active_out stays high until reset.

Decomposition:
- Shared package phy_pkg: COM_SYMBOL (8'hBC), SYNC_COUNT default, SYMBOL_W=8, FSM state encoding (SYNC=1'b0, ACTIVE=1'b1). The receiver uses the same package.
- One sub-module, tx_shifter8: bit counter plus load/shift register, producing data_out, byte_strobe_out and a boundary signal.
- Top level holds the FSM, the holding register and the handshake.

Test Plan:
- Release rst with valid_in=0: data_out repeats 1,0,1,1,1,1,0,0. byte_strobe_out high at edges 0,8,16,… after release. active_out rises after edge 24 (4th COM). ready_out=0 before that edge.
- After active, drive 0xA5 with valid_in for one accepted edge (edge 26): ready_out falls. Edge 32 loads the byte; data_out over edges 32–39 = 1,0,1,0,0,1,0,1 with data_flag_out=1. Edge 40 sends COM with data_flag_out=0.
- Hold valid_in=1 with 0x01, 0x02, 0x03 advancing on each transfer: each byte is accepted only on boundary edges once hold is full. Serial stream is 0x01,0x02,0x03 back-to-back with no COM between; then COM.
- Drive data_in=0xBC as data: transmitted bits 10111100 with data_flag_out=1.
- Assert rst mid-symbol (bit_cnt=3, hold full): all outputs go to 0 immediately. After release, the full 4-COM preamble repeats and the held byte is never sent.
- With SYNC_COUNT=1: active_out rises after edge 0 and the first data byte can be loaded at edge 8.
